// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external combinational ALU between two requesters. Each request
// (op select + two operands) is accepted with a valid/ready handshake,
// granted round-robin, driven to the ALU from registered copies for one full
// cycle, and the ALU result and flags are captured and returned on a single
// response bus tagged with the id of the requester that issued the op.
//
// Ports:
//   clk, rst_n                       clock (rising edge), async active-low reset
//   req{0,1}_valid/_ready            request handshake per requester
//   req{0,1}_S/_A/_B                 op select and operands per requester
//   alu_S, alu_A, alu_B              registered drive into the shared ALU
//   alu_out, alu_zero/_overflow/_cout  ALU result and flags
//   rsp_valid/rsp_ready              response handshake
//   rsp_id, rsp_out, rsp_zero/_overflow/_cout  captured response
//   grant_cnt0, grant_cnt1           saturating grant counters (optional)
//
// Build option: define ALU_ARB_STATS_EN to add the grant counters and their
// output ports. Arbitration and timing do not depend on it.
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_S,
  input  logic [WIDTH-1:0] req0_A,
  input  logic [WIDTH-1:0] req0_B,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_S,
  input  logic [WIDTH-1:0] req1_A,
  input  logic [WIDTH-1:0] req1_B,
  output logic [2:0]       alu_S,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             rsp_cout
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_reg, state_next;
  logic             last_grant_reg;
  logic [2:0]       op_s_reg;
  logic [WIDTH-1:0] op_a_reg, op_b_reg;
  logic             op_id_reg;
  logic             rsp_id_reg;
  logic [WIDTH-1:0] rsp_out_reg;
  logic             rsp_zero_reg, rsp_overflow_reg, rsp_cout_reg;

  logic             winner;
  logic             grant;

  // Round-robin: a lone requester always wins; on a tie the port that was
  // not granted last wins. last_grant resets to 1 so port 0 wins first tie.
  always_comb begin
    winner = 1'b0;
    if (req0_valid && req1_valid) begin
      winner = ~last_grant_reg;
    end else if (req1_valid) begin
      winner = 1'b1;
    end
  end

  // Depends only on state and the request valids, never on rsp_ready.
  assign grant = (state_reg == IDLE) && (req0_valid || req1_valid);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req0_ready = grant && !winner;
    req1_ready = grant && winner;
    rsp_valid  = (state_reg == RESP);
  end

  // Datapath: latch the winning op at grant, capture the ALU in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg   <= 1'b1;
      op_s_reg         <= '0;
      op_a_reg         <= '0;
      op_b_reg         <= '0;
      op_id_reg        <= 1'b0;
      rsp_id_reg       <= 1'b0;
      rsp_out_reg      <= '0;
      rsp_zero_reg     <= 1'b0;
      rsp_overflow_reg <= 1'b0;
      rsp_cout_reg     <= 1'b0;
    end else begin
      if (grant) begin
        last_grant_reg <= winner;
        op_id_reg      <= winner;
        op_s_reg       <= winner ? req1_S : req0_S;
        op_a_reg       <= winner ? req1_A : req0_A;
        op_b_reg       <= winner ? req1_B : req0_B;
      end
      if (state_reg == EXEC) begin
        rsp_id_reg       <= op_id_reg;
        rsp_out_reg      <= alu_out;
        rsp_zero_reg     <= alu_zero;
        rsp_overflow_reg <= alu_overflow;
        rsp_cout_reg     <= alu_cout;
      end
    end
  end

  // The ALU sees the latched op for the whole EXEC cycle.
  assign alu_S        = op_s_reg;
  assign alu_A        = op_a_reg;
  assign alu_B        = op_b_reg;
  assign rsp_id       = rsp_id_reg;
  assign rsp_out      = rsp_out_reg;
  assign rsp_zero     = rsp_zero_reg;
  assign rsp_overflow = rsp_overflow_reg;
  assign rsp_cout     = rsp_cout_reg;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant_cnt0_reg, grant_cnt1_reg;

  // Saturating grant counters; they stop at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0_reg <= '0;
      grant_cnt1_reg <= '0;
    end else begin
      if (req0_ready && (grant_cnt0_reg != 16'hFFFF)) begin
        grant_cnt0_reg <= grant_cnt0_reg + 16'd1;
      end
      if (req1_ready && (grant_cnt1_reg != 16'hFFFF)) begin
        grant_cnt1_reg <= grant_cnt1_reg + 16'd1;
      end
    end
  end

  assign grant_cnt0 = grant_cnt0_reg;
  assign grant_cnt1 = grant_cnt1_reg;
`else
  // Statistics disabled: no counters and no counter ports.
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Testbench for alu_arbiter. A small behavioural ALU sits on the alu_* bus
// (op 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR). Directed stimulus pushes the
// hand-computed response for every granted op into a queue; an independent
// monitor pops and compares each response as it transfers.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int W = 32;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2,
                         OP_OR = 3'd3, OP_XOR = 3'd4;

  typedef struct packed {
    logic         id;
    logic [W-1:0] out;
    logic         z;
    logic         o;
    logic         c;
  } rsp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]   req0_S, req1_S, alu_S;
  logic [W-1:0] req0_A, req0_B, req1_A, req1_B, alu_A, alu_B, alu_out;
  logic         alu_zero, alu_overflow, alu_cout;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0] rsp_out;
  logic         rsp_zero, rsp_overflow, rsp_cout;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]  grant_cnt0, grant_cnt1;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  rsp_t sb[$];

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_S(req0_S), .req0_A(req0_A), .req0_B(req0_B),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_S(req1_S), .req1_A(req1_A), .req1_B(req1_B),
    .alu_S(alu_S), .alu_A(alu_A), .alu_B(alu_B),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_zero(rsp_zero),
    .rsp_overflow(rsp_overflow), .rsp_cout(rsp_cout)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  // Behavioural ALU
  logic [W:0] wide;
  always_comb begin
    wide         = '0;
    alu_out      = '0;
    alu_overflow = 1'b0;
    alu_cout     = 1'b0;
    case (alu_S)
      OP_ADD: begin
        wide         = {1'b0, alu_A} + {1'b0, alu_B};
        alu_out      = wide[W-1:0];
        alu_cout     = wide[W];
        alu_overflow = (alu_A[W-1] == alu_B[W-1]) && (wide[W-1] != alu_A[W-1]);
      end
      OP_SUB: begin
        wide         = {1'b0, alu_A} + {1'b0, ~alu_B} + {{W{1'b0}}, 1'b1};
        alu_out      = wide[W-1:0];
        alu_cout     = wide[W];
        alu_overflow = (alu_A[W-1] != alu_B[W-1]) && (wide[W-1] != alu_A[W-1]);
      end
      OP_AND:  alu_out = alu_A & alu_B;
      OP_OR:   alu_out = alu_A | alu_B;
      OP_XOR:  alu_out = alu_A ^ alu_B;
      default: alu_out = '0;
    endcase
    alu_zero = (alu_out == '0);
  end

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: one comparison per transferred response.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      rsp_t got, exp;
      got = '{id: rsp_id, out: rsp_out, z: rsp_zero, o: rsp_overflow, c: rsp_cout};
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL rsp_unexpected: got id=%0d out=%h, expected no response",
                 got.id, got.out);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          n_bad++;
          $display("FAIL rsp: got id=%0d out=%h z=%0d o=%0d c=%0d, expected id=%0d out=%h z=%0d o=%0d c=%0d",
                   got.id, got.out, got.z, got.o, got.c,
                   exp.id, exp.out, exp.z, exp.o, exp.c);
        end else begin
          $display("rsp id=%0d out=%h z=%0d o=%0d c=%0d ok",
                   got.id, got.out, got.z, got.o, got.c);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op on one port, wait (bounded) for its grant, optionally
  // queue the expected response, then drop valid after the grant edge.
  task automatic issue(input bit port, input logic [2:0] s,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push, input rsp_t exp);
    bit got_it = 1'b0;
    if (port) begin
      req1_valid = 1'b1; req1_S = s; req1_A = a; req1_B = b;
    end else begin
      req0_valid = 1'b1; req0_S = s; req0_A = a; req0_B = b;
    end
    for (int i = 0; i < 30 && !got_it; i++) begin
      @(negedge clk);
      if ((port ? req1_ready : req0_ready) === 1'b1) begin
        got_it = 1'b1;
        if (push) sb.push_back(exp);
      end
      tick();
    end
    n_cmp++;
    if (!got_it) begin
      n_bad++;
      $display("FAIL grant_timeout: port %0d got no ready, expected ready within 30 cycles", port);
    end
    if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  // Wait until all queued responses have transferred and the bus is idle.
  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && rsp_valid === 1'b0) done = 1'b1;
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d responses pending, expected 0", sb.size());
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rsp_t e;
    logic [W-1:0] held;
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 0; req0_S = 0; req0_A = 0; req0_B = 0;
    req1_valid = 0; req1_S = 0; req1_A = 0; req1_B = 0;

    // Reset state
    #12;
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_req0_ready", {31'd0, req0_ready}, 32'd0);
    check("reset_alu_A", alu_A, 32'd0);
    check("reset_rsp_out", rsp_out, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Single request: ADD 5+7
    req0_valid = 1'b1; req0_S = OP_ADD; req0_A = 32'd5; req0_B = 32'd7;
    @(negedge clk);
    check("single_req0_ready", {31'd0, req0_ready}, 32'd1);
    check("single_req1_ready", {31'd0, req1_ready}, 32'd0);
    sb.push_back('{id: 1'b0, out: 32'd12, z: 1'b0, o: 1'b0, c: 1'b0});
    tick(); req0_valid = 1'b0;
    @(negedge clk);                       // T+1: EXEC
    check("exec_alu_A", alu_A, 32'd5);
    check("exec_alu_B", alu_B, 32'd7);
    check("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    @(negedge clk);                       // T+2: RESP
    check("resp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    drain();

    // Tie: last grant was port 0, so grants go 1,0,1,0 every 3 cycles.
    req0_valid = 1'b1; req0_S = OP_ADD; req0_A = 32'd1;    req0_B = 32'd2;
    req1_valid = 1'b1; req1_S = OP_XOR; req1_A = 32'hF0;   req1_B = 32'hFF;
    for (int k = 0; k < 10; k++) begin
      bit g0, g1;
      @(negedge clk);
      g1 = (k % 3 == 0) && ((k / 3) % 2 == 0);
      g0 = (k % 3 == 0) && ((k / 3) % 2 == 1);
      check($sformatf("tie_req0_ready_c%0d", k), {31'd0, req0_ready}, {31'd0, g0});
      check($sformatf("tie_req1_ready_c%0d", k), {31'd0, req1_ready}, {31'd0, g1});
      if (g0) sb.push_back('{id: 1'b0, out: 32'd3, z: 1'b0, o: 1'b0, c: 1'b0});
      if (g1) sb.push_back('{id: 1'b1, out: 32'h0F, z: 1'b0, o: 1'b0, c: 1'b0});
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();

    // Flags
    e = '{id: 1'b1, out: 32'h80000000, z: 1'b0, o: 1'b1, c: 1'b0};
    issue(1'b1, OP_ADD, 32'h7FFFFFFF, 32'd1, 1'b1, e);
    e = '{id: 1'b0, out: 32'd0, z: 1'b1, o: 1'b0, c: 1'b1};
    issue(1'b0, OP_SUB, 32'd9, 32'd9, 1'b1, e);
    drain();

    // Backpressure: response held for 5 cycles with req1 waiting.
    rsp_ready = 1'b0;
    e = '{id: 1'b0, out: 32'h0F000F00, z: 1'b0, o: 1'b0, c: 1'b0};
    issue(1'b0, OP_AND, 32'hFF00FF00, 32'h0FF00FF0, 1'b1, e);
    req1_valid = 1'b1; req1_S = OP_OR; req1_A = 32'h12340000; req1_B = 32'h00005678;
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rsp_out", rsp_out, 32'h0F000F00);
      check("bp_rsp_id", {31'd0, rsp_id}, 32'd0);
      check("bp_req1_ready", {31'd0, req1_ready}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    check("bp_after_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("bp_after_req1_ready", {31'd0, req1_ready}, 32'd1);
    sb.push_back('{id: 1'b1, out: 32'h12345678, z: 1'b0, o: 1'b0, c: 1'b0});
    tick(); req1_valid = 1'b0;
    drain();

    // Reset during EXEC: discarded op, outputs clear without a clock.
    issue(1'b0, OP_XOR, 32'h100, 32'h23, 1'b0, e);
    #2;
    check("midop_alu_A_before", alu_A, 32'h100);
    rst_n = 1'b0;
    #1;
    check("midop_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midop_alu_S", {29'd0, alu_S}, 32'd0);
    check("midop_alu_A", alu_A, 32'd0);
    check("midop_alu_B", alu_B, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    req0_valid = 1'b1; req0_S = OP_ADD; req0_A = 32'hFFFFFFFF; req0_B = 32'd1;
    req1_valid = 1'b1; req1_S = OP_AND; req1_A = 32'd6;        req1_B = 32'd3;
    #1;
    check("postrst_tie_req0_ready", {31'd0, req0_ready}, 32'd1);
    check("postrst_tie_req1_ready", {31'd0, req1_ready}, 32'd0);
    sb.push_back('{id: 1'b0, out: 32'd0, z: 1'b1, o: 1'b0, c: 1'b1});
    tick(); req0_valid = 1'b0; req1_valid = 1'b0;
    drain();

`ifdef ALU_ARB_STATS_EN
    // One grant to port 0 since reset; add 3 more to port 0 and 2 to port 1.
    for (int k = 0; k < 3; k++) begin
      e = '{id: 1'b0, out: 32'd1, z: 1'b0, o: 1'b0, c: 1'b0};
      issue(1'b0, OP_AND, 32'd3, 32'd5, 1'b1, e);
      if (k < 2) begin
        e = '{id: 1'b1, out: 32'd9, z: 1'b0, o: 1'b0, c: 1'b0};
        issue(1'b1, OP_OR, 32'd8, 32'd1, 1'b1, e);
      end
    end
    drain();
    check("stats_cnt0", {16'd0, grant_cnt0}, 32'd4);
    check("stats_cnt1", {16'd0, grant_cnt1}, 32'd2);
    force dut.grant_cnt0_reg = 16'hFFFF;
    #1;
    release dut.grant_cnt0_reg;
    e = '{id: 1'b0, out: 32'd1, z: 1'b0, o: 1'b0, c: 1'b0};
    issue(1'b0, OP_AND, 32'd3, 32'd5, 1'b1, e);
    drain();
    check("stats_cnt0_sat", {16'd0, grant_cnt0}, 32'h0000FFFF);
    check("stats_cnt1_hold", {16'd0, grant_cnt1}, 32'd2);
`endif

    held = sb.size();
    check("scoreboard_empty", held, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
